// File: rtl/capture_pkg.sv
// Shared types and default sizing for the sample_capture acquisition stage.
package capture_pkg;
  localparam int DEF_SAMPLE_W     = 8;
  localparam int DEF_DEPTH        = 256;
  localparam int DEF_DECIM_W      = 8;
  localparam int DEF_AUTO_TIMEOUT = 2_000_000;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    HOLD      = 2'd3
  } capture_state_t;

  typedef logic [DEF_SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_capture_trigger_detect.sv
// Level-crossing detector: keeps the previous sample and a prime flag so the
// first sample after (re)arming only seeds prev and can never fire.
module trigger_detect
  import capture_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                track,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  output logic                trig
);
  logic [SAMPLE_W-1:0] prev;
  logic                primed;
  logic                rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      primed <= 1'b0;
    end else if (!track) begin
      primed <= 1'b0;
    end else if (sample_valid) begin
      prev   <= sample;
      primed <= 1'b1;
    end
  end

  always_comb begin
    rise = (prev < trig_level) && (sample >= trig_level);
    fall = (prev > trig_level) && (sample <= trig_level);
    trig = track && primed && sample_valid && (trig_falling ? fall : rise);
  end
endmodule

// File: rtl/sample_capture.sv
// Decimating triggered capture with blanking-synchronous frame commit.
// Optional forced trigger after a timeout: SAMPLE_CAPTURE_AUTO_TRIG_EN.
module sample_capture
  import capture_pkg::*;
#(
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DECIM_W      = DEF_DECIM_W,
  parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic [SAMPLE_W-1:0]            sample,
  input  logic [SAMPLE_W-1:0]            trig_level,
  input  logic                           trig_falling,
  input  logic [DECIM_W-1:0]             decim,
  input  logic                           hold,
  input  logic                           frame_blank,
  output logic [DEPTH-1:0][SAMPLE_W-1:0] frame,
  output logic                           frame_valid,
  output logic [1:0]                     state_o,
  output logic                           trig_auto
);
  localparam int IDX_W = $clog2(DEPTH);

  capture_state_t                state, state_nx;
  logic [DEPTH-1:0][SAMPLE_W-1:0] buffer;
  logic [IDX_W-1:0]              idx;
  logic [DECIM_W-1:0]            cnt, decim_q;
  logic                          cap_auto;
  logic                          track, trig, fire, fire_auto, take, commit;

  assign track   = (state == ARM) || (state == WAIT_TRIG);
  assign state_o = state;

  trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk          (clk),
    .rst          (rst),
    .track        (track),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .trig         (trig)
  );

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;
  logic [TO_W-1:0] wait_cnt;
  logic            timed_out;

  // Saturates at the timeout so the forced trigger waits for a real sample.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_TRIG) wait_cnt <= '0;
    else if (!timed_out)           wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (wait_cnt == TO_W'(AUTO_TIMEOUT - 1));
  assign fire_auto = (state == WAIT_TRIG) && sample_valid && timed_out && !trig;
`else
  // Without the auto trigger the timeout value has no effect.
  assign fire_auto = 1'b0 && (AUTO_TIMEOUT > 0);
`endif

  assign fire = (state == WAIT_TRIG) && (trig || fire_auto);

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    commit   = 1'b0;
    case (state)
      ARM:       if (sample_valid) state_nx = WAIT_TRIG;
      WAIT_TRIG: if (fire) state_nx = CAPTURE;
      CAPTURE: begin
        take = sample_valid && (cnt == '0);
        if (take && idx == IDX_W'(DEPTH - 1)) state_nx = HOLD;
      end
      HOLD: begin
        commit = frame_blank && !hold;
        if (commit) state_nx = ARM;
      end
      default: state_nx = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      buffer      <= '0;
      frame       <= '0;
      idx         <= '0;
      cnt         <= '0;
      decim_q     <= '0;
      cap_auto    <= 1'b0;
      trig_auto   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_valid <= commit;
      if (state == ARM) decim_q <= decim;
      if (fire) begin
        buffer[0] <= sample;
        idx       <= IDX_W'(1);
        cnt       <= decim_q;
        cap_auto  <= fire_auto;
      end
      if (state == CAPTURE && sample_valid) begin
        if (take) begin
          buffer[idx] <= sample;
          idx         <= idx + 1'b1;
          cnt         <= decim_q;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (commit) begin
        frame     <= buffer;
        trig_auto <= cap_auto;
      end
    end
  end
endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture: directed table, hold/reset sequences,
// randomized captures against a sample-list reference model.
module tb_sample_capture;
  import capture_pkg::*;
  localparam int DEPTH = 256;
  localparam int TMO   = 1000;

  logic                  clk = 1'b0;
  logic                  rst, sample_valid, trig_falling, hold, frame_blank;
  sample_t               sample, trig_level;
  logic [7:0]            decim;
  logic [DEPTH-1:0][7:0] frame;
  logic                  frame_valid, trig_auto;
  logic [1:0]            state_o;

  sample_capture #(.SAMPLE_W(8), .DEPTH(DEPTH), .DECIM_W(8), .AUTO_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .trig_falling(trig_falling), .decim(decim),
    .hold(hold), .frame_blank(frame_blank), .frame(frame),
    .frame_valid(frame_valid), .state_o(state_o), .trig_auto(trig_auto)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seen[$];
  int mexp[DEPTH];
  int pexp[DEPTH];
  bit mok;

  typedef struct {
    int pat; int falling; int level; int decim;
    int ia; int va; int ib; int vb;
  } vec_t;
  vec_t tbl[3];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input string name, input bit use_prev);
    int nd = 0; int fi = -1; int e;
    for (int k = 0; k < DEPTH; k++) begin
      e = use_prev ? pexp[k] : mexp[k];
      if (int'(frame[k]) != e) begin
        nd++;
        if (fi < 0) fi = k;
      end
    end
    total++;
    if (nd != 0) begin
      bad++;
      e = use_prev ? pexp[fi] : mexp[fi];
      $display("FAIL %s idx=%0d act=%0d exp=%0d (%0d entries differ)", name, fi, frame[fi], e, nd);
    end
  endtask

  function automatic int gen(input int pat, input int n);
    case (pat)
      0: return n % 256;
      1: return (n == 0) ? 50 : 255 - ((n - 1) % 256);
      2: return int'($urandom_range(255, 0));
      default: return 16;
    endcase
  endfunction

  // Reference: first consecutive valid pair that crosses, then every (decim+1)th.
  task automatic model(input int falling, input int level, input int dec);
    int t = -1; int p; int s; int j;
    mok = 1'b1;
    for (int i = 1; i < seen.size() && t < 0; i++) begin
      p = seen[i-1]; s = seen[i];
      if (falling != 0 ? (p > level && s <= level) : (p < level && s >= level)) t = i;
    end
    if (t < 0) mok = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      j = t + k * (dec + 1);
      if (t < 0 || j >= seen.size()) begin
        mok = 1'b0;
        mexp[k] = -1;
      end else begin
        mexp[k] = seen[j];
      end
    end
  endtask

  task automatic acquire(input string name, input int pat, input int gap_max);
    int n = 0; int cyc = 0; bit ok = 1'b0;
    seen.delete();
    while (cyc < 6000) begin
      if (state_o == 2'd3) begin
        ok = 1'b1;
        break;
      end
      if (gap_max > 0 && $urandom_range(gap_max, 0) != 0) begin
        sample_valid = 1'b0;
      end else begin
        sample_valid = 1'b1;
        sample = 8'(gen(pat, n));
        seen.push_back(int'(sample));
        n++;
      end
      step();
      cyc++;
    end
    sample_valid = 1'b0;
    chk({name, "_reached_hold"}, int'(ok), 1);
  endtask

  task automatic commit_chk(input string name);
    chk({name, "_fv_before"}, int'(frame_valid), 0);
    frame_blank = 1'b1;
    step();
    chk({name, "_fv_pulse"}, int'(frame_valid), 1);
    chk({name, "_state_arm"}, int'(state_o), 0);
    frame_blank = 1'b0;
    step();
    chk({name, "_fv_single"}, int'(frame_valid), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    rst = 1'b1; sample_valid = 1'b0; sample = '0; trig_level = 8'd100;
    trig_falling = 1'b0; decim = '0; hold = 1'b0; frame_blank = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", int'(state_o), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_auto", int'(trig_auto), 0);
    nz = 0;
    for (int k = 0; k < DEPTH; k++) if (frame[k] != 8'd0) nz++;
    chk("rst_frame_nonzero", nz, 0);

    tbl[0] = '{0, 0, 100, 0, 0, 100, 255, 99};
    tbl[1] = '{0, 0, 100, 3, 1, 104, 39, 0};
    tbl[2] = '{1, 1, 50,  0, 0, 50,  1,  49};
    for (int v = 0; v < 3; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      trig_level   = 8'(tbl[v].level);
      trig_falling = tbl[v].falling[0];
      decim        = 8'(tbl[v].decim);
      acquire(nm, tbl[v].pat, 0);
      model(tbl[v].falling, tbl[v].level, tbl[v].decim);
      chk({nm, "_model_ok"}, int'(mok), 1);
      commit_chk(nm);
      cmp_frame({nm, "_frame"}, 1'b0);
      chk({nm, "_spot_a"}, int'(frame[tbl[v].ia]), tbl[v].va);
      chk({nm, "_spot_b"}, int'(frame[tbl[v].ib]), tbl[v].vb);
      chk({nm, "_trig_auto"}, int'(trig_auto), 0);
    end

    // hold blocks commit across many blanking intervals
    for (int k = 0; k < DEPTH; k++) pexp[k] = mexp[k];
    trig_level = 8'd100; trig_falling = 1'b0; decim = 8'd0; hold = 1'b1;
    acquire("hold", 0, 0);
    model(0, 100, 0);
    for (int f = 0; f < 10; f++) begin
      frame_blank = 1'b1; step(); step(); step();
      frame_blank = 1'b0; step(); step(); step();
    end
    chk("hold_state", int'(state_o), 3);
    chk("hold_fv", int'(frame_valid), 0);
    cmp_frame("hold_frame_kept", 1'b1);
    frame_blank = 1'b1; hold = 1'b0;
    step();
    chk("release_fv", int'(frame_valid), 1);
    chk("release_state", int'(state_o), 0);
    cmp_frame("release_frame", 1'b0);
    frame_blank = 1'b0;
    step();

    // reset while capture index is 120
    trig_level = 8'd100; trig_falling = 1'b0; decim = 8'd0;
    for (int n = 0; n < 220; n++) begin
      sample_valid = 1'b1; sample = 8'(n);
      step();
    end
    sample_valid = 1'b0;
    chk("midcap_state", int'(state_o), 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_fv", int'(frame_valid), 0);
    nz = 0;
    for (int k = 0; k < DEPTH; k++) if (frame[k] != 8'd0) nz++;
    chk("midrst_frame_nonzero", nz, 0);

    // randomized captures
    for (int r = 0; r < 6; r++) begin
      string nm;
      int lv, fl, dc;
      nm = $sformatf("rnd%0d", r);
      lv = int'($urandom_range(195, 60));
      fl = int'($urandom_range(1, 0));
      dc = int'($urandom_range(2, 0));
      trig_level = 8'(lv); trig_falling = fl[0]; decim = 8'(dc);
      acquire(nm, 2, 2);
      model(fl, lv, dc);
      chk({nm, "_model_ok"}, int'(mok), 1);
      commit_chk(nm);
      cmp_frame({nm, "_frame"}, 1'b0);
      chk({nm, "_trig_auto"}, int'(trig_auto), 0);
    end

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
    trig_level = 8'h80; trig_falling = 1'b0; decim = 8'd0;
    acquire("auto", 3, 0);
    for (int k = 0; k < DEPTH; k++) mexp[k] = 16;
    commit_chk("auto");
    cmp_frame("auto_frame", 1'b0);
    chk("auto_flag", int'(trig_auto), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
